sipo_shift_rx: RTL and testbench

SIPO_SHIFT_RX -- requirements
Module: sipo_shift_rx

---
 rtl/sipo_shift_rx.sv | 177 +++++++++++++++++
 tb/tb_sipo_shift_rx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_shift_rx.sv
// ---------------------------------------------------------------------------
// sipo_shift_rx
//
// Serial-in / parallel-out frame receiver. A frame begins with an i_start
// request in IDLE. Each bit-strobe (i_en=1) then shifts one bit of i_din
// into the word, MSB first. Once WIDTH bits have arrived, the assembled word
// is presented on o_dout. o_valid pulses for the single cycle the FSM spends
// in DONE.
//
// Optional feature macro: SIPO_PARITY_EN
//   When defined, each frame carries one extra even-parity bit after the
//   data bits. o_perr then reports (^data) ^ parity_bit, and it is updated
//   together with o_dout. When undefined, the PAR state and all parity logic
//   are absent, and o_perr is tied to 0.
//
// Parameters:
//   WIDTH    data word length in bits (2..32)
//
// Ports:
//   i_clk    input   1      rising-edge clock
//   i_rstn   input   1      synchronous active-low reset
//   i_din    input   1      serial data bit (already registered upstream)
//   i_en     input   1      bit strobe; i_din consumed only when high
//   i_start  input   1      frame start request (honoured only in IDLE)
//   o_dout   output  WIDTH  last completed parallel word
//   o_valid  output  1      one-cycle pulse marking a new o_dout
//   o_busy   output  1      high while a frame is being received
//   o_perr   output  1      parity error flag for the last frame
// ---------------------------------------------------------------------------
module sipo_shift_rx #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_din,
   input  logic             i_en,
   input  logic             i_start,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_valid,
   output logic             o_busy,
   output logic             o_perr
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
   // The full word must be held in PAR while waiting for the parity bit.
   localparam int SHW = WIDTH;
   typedef enum logic [1:0] {IDLE, SHIFT, PAR, DONE} state_t;
`else
   // Without parity, the final bit goes straight from i_din into o_dout.
   // The shift register therefore only needs the first WIDTH-1 bits.
   localparam int SHW = WIDTH - 1;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t           state;
   state_t           next_state;
   logic [SHW-1:0]   sh;
   logic [SHW-1:0]   sh_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] dout_nxt;
   logic [WIDTH-1:0] word;

   // State register. Reset returns the FSM to IDLE and overrides any start
   // request or strobe arriving on the same edge.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Datapath registers. Clearing them on reset discards any partial frame.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         sh     <= '0;
         cnt    <= '0;
         o_dout <= '0;
      end else begin
         sh     <= sh_nxt;
         cnt    <= cnt_nxt;
         o_dout <= dout_nxt;
      end
   end

`ifdef SIPO_PARITY_EN
   logic perr;
   logic perr_nxt;

   // Parity flag register. It only changes on entry to DONE.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         perr <= 1'b0;
      end else begin
         perr <= perr_nxt;
      end
   end

   assign o_perr = perr;
`else
   assign o_perr = 1'b0;
`endif

   // Word as it looks once the current i_din is appended. In both builds this
   // equals {sh[WIDTH-2:0], i_din}, i.e. the MSB-first shift.
`ifdef SIPO_PARITY_EN
   assign word = {sh[WIDTH-2:0], i_din};
`else
   assign word = {sh, i_din};
`endif

   // Next-state, next-datapath and output decode. Every target holds its
   // value by default. The counter stops at WIDTH-1 rather than wrapping,
   // because leaving SHIFT is what ends the frame.
   always_comb begin
      next_state = state;
      sh_nxt     = sh;
      cnt_nxt    = cnt;
      dout_nxt   = o_dout;
`ifdef SIPO_PARITY_EN
      perr_nxt   = perr;
`endif
      o_valid    = 1'b0;
      o_busy     = 1'b0;

      case (state)
         IDLE: begin
            if (i_start) begin
               next_state = SHIFT;
               cnt_nxt    = '0;
            end
         end

         SHIFT: begin
            o_busy = 1'b1;
            if (i_en) begin
               sh_nxt = word[SHW-1:0];
               if (cnt == LAST) begin
`ifdef SIPO_PARITY_EN
                  next_state = PAR;
`else
                  next_state = DONE;
                  dout_nxt   = word;
`endif
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end

`ifdef SIPO_PARITY_EN
         PAR: begin
            o_busy = 1'b1;
            if (i_en) begin
               next_state = DONE;
               dout_nxt   = sh;
               perr_nxt   = (^sh) ^ i_din;
            end
         end
`endif

         DONE: begin
            o_valid    = 1'b1;
            next_state = IDLE;
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sipo_shift_rx.sv
// ---------------------------------------------------------------------------
// tb_sipo_shift_rx
//
// Scoreboard bench for sipo_shift_rx with WIDTH=8. The stimulus tasks push
// the expected word and parity flag into a queue. A monitor pops and
// compares on every o_valid cycle. Build with SIPO_PARITY_EN defined to
// exercise the parity variant.
// ---------------------------------------------------------------------------
module tb_sipo_shift_rx;

   localparam int W = 8;
`ifdef SIPO_PARITY_EN
   localparam int STROBES = W + 1;
`else
   localparam int STROBES = W;
`endif

   typedef struct {
      logic [W-1:0] dout;
      logic         perr;
   } exp_t;

   logic         clk;
   logic         i_rstn;
   logic         i_din;
   logic         i_en;
   logic         i_start;
   logic [W-1:0] o_dout;
   logic         o_valid;
   logic         o_busy;
   logic         o_perr;

   int   checks;
   int   errors;
   int   cycle;
   int   busyCount;
   exp_t sb[$];
   int   validCycles[$];

   sipo_shift_rx #(.WIDTH(W)) dut (
      .i_clk   (clk),
      .i_rstn  (i_rstn),
      .i_din   (i_din),
      .i_en    (i_en),
      .i_start (i_start),
      .o_dout  (o_dout),
      .o_valid (o_valid),
      .o_busy  (o_busy),
      .o_perr  (o_perr)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and busy-cycle counter used for timing checks.
   always @(posedge clk) cycle++;
   always @(negedge clk) if (o_busy === 1'b1) busyCount++;

   // Record one comparison, and report it if the actual value disagrees.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every valid word must match the oldest scoreboard entry.
   always @(negedge clk) begin
      if (o_valid === 1'b1) begin
         validCycles.push_back(cycle);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_valid: got dout %0h with empty scoreboard", o_dout);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("sb_dout", 32'(o_dout), 32'(e.dout));
            checkOutput("sb_perr", 32'(o_perr), 32'(e.perr));
         end
      end
   end

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic expPerr(input logic [W-1:0] word, input logic par);
`ifdef SIPO_PARITY_EN
      return (^word) ^ par;
`else
      return 1'b0 & (^word) & par;
`endif
   endfunction

   // Send one frame: start pulse, then the bits MSB first. gap idle cycles
   // precede each strobe. The parity bit follows when the feature is
   // compiled in.
   task automatic applyStimulus(input logic [W-1:0] word, input int gap, input logic par);
      int b0;
      sb.push_back('{word, expPerr(word, par)});
      b0 = busyCount;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int b = W - 1; b >= 0; b--) begin
         repeat (gap) begin
            i_en = 1'b0;
            tick();
         end
         i_din = word[b];
         i_en  = 1'b1;
         tick();
      end
`ifdef SIPO_PARITY_EN
      repeat (gap) begin
         i_en = 1'b0;
         tick();
      end
      i_din = par;
      i_en  = 1'b1;
      tick();
`endif
      i_en  = 1'b0;
      i_din = 1'b0;
      checkOutput("valid_after_last_bit", 32'(o_valid), 32'd1);
      checkOutput("busy_in_done", 32'(o_busy), 32'd0);
      tick();
      checkOutput("valid_one_cycle", 32'(o_valid), 32'd0);
      checkOutput("busy_cycles", 32'(busyCount - b0), 32'(STROBES * (gap + 1)));
   endtask

   // Watchdog, so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int vc0;
      checks    = 0;
      errors    = 0;
      cycle     = 0;
      busyCount = 0;
      i_rstn    = 1'b0;
      i_din     = 1'b0;
      i_en      = 1'b0;
      i_start   = 1'b0;

      // Reset held for 3 cycles while the other inputs toggle.
      for (int i = 0; i < 3; i++) begin
         i_din   = ~i_din;
         i_en    = ~i_en;
         i_start = ~i_start;
         tick();
         checkOutput("rst_dout", 32'(o_dout), 32'd0);
         checkOutput("rst_valid", 32'(o_valid), 32'd0);
         checkOutput("rst_busy", 32'(o_busy), 32'd0);
         checkOutput("rst_perr", 32'(o_perr), 32'd0);
      end
      i_rstn  = 1'b1;
      i_din   = 1'b0;
      i_en    = 1'b0;
      i_start = 1'b0;
      tick();
      tick();

      // Basic frame, strobe every cycle.
      applyStimulus(8'hB2, 0, 1'b0);
      checkOutput("dout_hold", 32'(o_dout), 32'hB2);

      // Same frame, strobe on alternate cycles.
      applyStimulus(8'hB2, 1, 1'b0);

      // Parity set to 1: a parity error in the parity build, 0 otherwise.
      applyStimulus(8'hB2, 0, 1'b1);

      // Reset after 4 bits discards the partial word.
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int b = 0; b < 4; b++) begin
         i_din = b[0];
         i_en  = 1'b1;
         tick();
      end
      i_en   = 1'b0;
      i_rstn = 1'b0;
      tick();
      checkOutput("midrst_busy", 32'(o_busy), 32'd0);
      checkOutput("midrst_dout", 32'(o_dout), 32'd0);
      i_rstn = 1'b1;
      tick();
      checkOutput("midrst_no_valid", 32'(o_valid), 32'd0);
      applyStimulus(8'h5A, 0, 1'b0);

      // Start held high through two back-to-back frames of all ones.
      vc0 = validCycles.size();
      sb.push_back('{8'hFF, expPerr(8'hFF, 1'b1)});
      sb.push_back('{8'hFF, expPerr(8'hFF, 1'b1)});
      i_start = 1'b1;
      i_en    = 1'b1;
      i_din   = 1'b1;
      repeat (2 * (STROBES + 2)) tick();
      i_start = 1'b0;
      i_en    = 1'b0;
      i_din   = 1'b0;
      repeat (3) tick();
      checkOutput("held_start_valids", 32'(validCycles.size() - vc0), 32'd2);
      if (validCycles.size() >= vc0 + 2)
         checkOutput("held_start_spacing", 32'(validCycles[vc0 + 1] - validCycles[vc0]),
                     32'(STROBES + 2));
      checkOutput("held_start_idle", 32'(o_busy), 32'd0);

      // Drain the scoreboard within a bounded time.
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
